// File: rtl/swire_pkg.sv
// Shared types and constants for the swire transmission scheduler.
package swire_pkg;
  localparam int SWIRE_DW = 16;

  localparam logic SEL_B1 = 1'b0;
  localparam logic SEL_B5 = 1'b1;

  typedef enum logic [2:0] {BOOT, IDLE, LAUNCH, WAIT, GAP} state_t;

  typedef struct packed {
    logic                valid;
    logic [SWIRE_DW-1:0] data;
  } strobe_t;
endpackage

// File: rtl/swire_sched_if.sv
// Register-strobe inputs and transmitter handshake of the swire scheduler.
interface swire_sched_if;
  logic                          i_b1_valid;
  logic [swire_pkg::SWIRE_DW-1:0] i_b1_data;
  logic                          i_b5_valid;
  logic [swire_pkg::SWIRE_DW-1:0] i_b5_data;
  logic                          i_tx_done;
  logic                          o_tx_start;
  logic                          o_tx_sel;
  logic [swire_pkg::SWIRE_DW-1:0] o_tx_data;
  logic                          o_busy;
  logic                          o_timeout;

  modport master (
    input  i_b1_valid, i_b1_data, i_b5_valid, i_b5_data, i_tx_done,
    output o_tx_start, o_tx_sel, o_tx_data, o_busy, o_timeout
  );

  modport slave (
    output i_b1_valid, i_b1_data, i_b5_valid, i_b5_data, i_tx_done,
    input  o_tx_start, o_tx_sel, o_tx_data, o_busy, o_timeout
  );
endinterface

// File: rtl/swire_pend_slot.sv
// One pending-update slot: latest-wins data register plus pend flag.
// SWIRE_SCHED_DEDUP_EN suppresses strobes that repeat the last completed word.
module swire_pend_slot
  import swire_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  strobe_t             stb,
  input  logic                clr,
  input  logic                sent,
  input  logic [SWIRE_DW-1:0] sent_word,
  output logic                pend,
  output logic [SWIRE_DW-1:0] data
);
  logic set, wr;

`ifdef SWIRE_SCHED_DEDUP_EN
  logic [SWIRE_DW-1:0] last_sent;

  assign set = stb.valid & (stb.data != last_sent);
  assign wr  = set | (stb.valid & pend);

  // only frames acknowledged by done count as sent; aborts leave it alone
  always_ff @(posedge clk or posedge rst)
    if (rst)       last_sent <= '0;
    else if (sent) last_sent <= sent_word;
`else
  logic unused;

  assign set    = stb.valid;
  assign wr     = stb.valid;
  assign unused = ^{sent, sent_word};
`endif

  // a strobe in the launch cycle keeps pend set so the new word goes next
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pend <= 1'b0;
      data <= '0;
    end else begin
      if (wr)       data <= stb.data;
      if (set)      pend <= 1'b1;
      else if (clr) pend <= 1'b0;
    end
endmodule

// File: rtl/swire_sched.sv
// Swire frame scheduler: B1/B5 round-robin, boot hold-off, inter-frame gap,
// done watchdog. Optional SWIRE_SCHED_DEDUP_EN handled in swire_pend_slot.
module swire_sched
  import swire_pkg::*;
#(
  parameter logic [23:0] STARTUP_DLY = 24'hfffff0,
  parameter logic [15:0] GAP_CYCLES  = 16'd380,
  parameter logic [19:0] TX_TIMEOUT  = 20'd760000
) (
  input logic           i_clk_38m,
  input logic           i_reset,
  swire_sched_if.master bus
);
  state_t                   state;
  logic [23:0]              cnt;
  logic [24:0]              cnt_inc;
  logic                     last_sel, sel_nxt, launch;
  logic                     tx_start, tx_sel, busy, timeout;
  logic [SWIRE_DW-1:0]      tx_data;
  strobe_t [1:0]            stb;
  logic [1:0]               pend, clr, done_upd;
  logic [1:0][SWIRE_DW-1:0] slot_data;

  assign stb[SEL_B1] = {bus.i_b1_valid, bus.i_b1_data};
  assign stb[SEL_B5] = {bus.i_b5_valid, bus.i_b5_data};

  // tie goes to the channel not launched last; otherwise the only pending one
  assign sel_nxt = (pend == 2'b11) ? ~last_sel : pend[SEL_B5];
  assign launch  = (state == IDLE) & (|pend);

  for (genvar c = 0; c < 2; c++) begin : g_slot
    localparam logic CH = 1'(c);
    assign clr[c]      = launch & (sel_nxt == CH);
    assign done_upd[c] = (state == WAIT) & bus.i_tx_done & (tx_sel == CH);
    swire_pend_slot u_slot (
      .clk       (i_clk_38m),
      .rst       (i_reset),
      .stb       (stb[c]),
      .clr       (clr[c]),
      .sent      (done_upd[c]),
      .sent_word (tx_data),
      .pend      (pend[c]),
      .data      (slot_data[c])
    );
  end

  // "cnt+1 >= limit" lets a zero limit still spend exactly one cycle in state
  assign cnt_inc = {1'b0, cnt} + 25'd1;

  always_ff @(posedge i_clk_38m or posedge i_reset)
    if (i_reset) begin
      state    <= BOOT;
      cnt      <= '0;
      last_sel <= 1'b1;
      tx_start <= 1'b0;
      tx_sel   <= 1'b0;
      tx_data  <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      if (cnt != '1) cnt <= cnt + 24'd1;
      case (state)
        BOOT:
          if (cnt_inc >= 25'(STARTUP_DLY)) begin
            state <= IDLE;
            cnt   <= '0;
          end
        IDLE: begin
          cnt <= '0;
          if (launch) begin
            state    <= LAUNCH;
            tx_start <= 1'b1;
            tx_sel   <= sel_nxt;
            tx_data  <= slot_data[sel_nxt];
            last_sel <= sel_nxt;
            busy     <= 1'b1;
          end
        end
        LAUNCH: begin
          state <= WAIT;
          cnt   <= '0;
        end
        WAIT:
          if (bus.i_tx_done) begin
            state <= GAP;
            cnt   <= '0;
          end else if (cnt_inc >= 25'(TX_TIMEOUT)) begin
            state   <= GAP;
            cnt     <= '0;
            timeout <= 1'b1;
          end
        GAP:
          if (cnt_inc >= 25'(GAP_CYCLES)) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        default: begin
          state <= BOOT;
          cnt   <= '0;
        end
      endcase
    end

  assign bus.o_tx_start = tx_start;
  assign bus.o_tx_sel   = tx_sel;
  assign bus.o_tx_data  = tx_data;
  assign bus.o_busy     = busy;
  assign bus.o_timeout  = timeout;
endmodule

// File: tb/tb_swire_sched.sv
// Directed bench for swire_sched with short boot/gap/timeout parameters.
module tb_swire_sched;
  logic i_clk_38m = 1'b0;
  logic i_reset   = 1'b1;
  int   total = 0;
  int   bad   = 0;

  swire_sched_if bus ();

  swire_sched #(
    .STARTUP_DLY (24'd100),
    .GAP_CYCLES  (16'd4),
    .TX_TIMEOUT  (20'd50)
  ) dut (
    .i_clk_38m (i_clk_38m),
    .i_reset   (i_reset),
    .bus       (bus)
  );

  always #5 i_clk_38m = ~i_clk_38m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge i_clk_38m);
      #1;
    end
  endtask

  task automatic strobe(input logic b1v, input logic [15:0] b1d,
                        input logic b5v, input logic [15:0] b5d);
    bus.i_b1_valid = b1v; bus.i_b1_data = b1d;
    bus.i_b5_valid = b5v; bus.i_b5_data = b5d;
    tick();
    bus.i_b1_valid = 1'b0;
    bus.i_b5_valid = 1'b0;
  endtask

  task automatic send_done();
    bus.i_tx_done = 1'b1;
    tick();
    bus.i_tx_done = 1'b0;
  endtask

  task automatic wait_start(input string tag, input logic s, input logic [15:0] d);
    int n = 0;
    while (!bus.o_tx_start && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_seen"}, 32'(bus.o_tx_start), 32'd1);
    chk({tag, "_sel"},  32'(bus.o_tx_sel),   32'(s));
    chk({tag, "_data"}, 32'(bus.o_tx_data),  32'(d));
  endtask

  task automatic count_starts(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      if (bus.o_tx_start) cnt++;
      tick();
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_start"},   32'(bus.o_tx_start), 32'd0);
    chk({tag, "_sel"},     32'(bus.o_tx_sel),   32'd0);
    chk({tag, "_data"},    32'(bus.o_tx_data),  32'd0);
    chk({tag, "_busy"},    32'(bus.o_busy),     32'd0);
    chk({tag, "_timeout"}, 32'(bus.o_timeout),  32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bus.i_b1_valid = 1'b0; bus.i_b1_data = '0;
    bus.i_b5_valid = 1'b0; bus.i_b5_data = '0;
    bus.i_tx_done  = 1'b0;
    tick(2);
    chk_zero("rst");

    // boot hold-off: strobe at cycle 10, launch at cycle 101
    i_reset = 1'b0;
    tick(10);
    strobe(1'b1, 16'h0123, 1'b0, 16'h0);
    tick(89);
    chk("lat_early", 32'(bus.o_tx_start), 32'd0);
    tick();
    chk("lat_start", 32'(bus.o_tx_start), 32'd1);
    chk("lat_sel",   32'(bus.o_tx_sel),   32'd0);
    chk("lat_data",  32'(bus.o_tx_data),  32'h0123);
    chk("lat_busy",  32'(bus.o_busy),     32'd1);

    // latest-wins overwrite while in flight; done-to-start spacing GAP+2
    tick();
    strobe(1'b1, 16'h0001, 1'b0, 16'h0);
    strobe(1'b1, 16'h0002, 1'b0, 16'h0);
    chk("hold_data", 32'(bus.o_tx_data), 32'h0123);
    send_done();
    tick(4);
    chk("gap_early", 32'(bus.o_tx_start), 32'd0);
    chk("gap_busy",  32'(bus.o_busy),     32'd0);
    tick();
    chk("gap_start", 32'(bus.o_tx_start), 32'd1);
    chk("ow_data",   32'(bus.o_tx_data),  32'h0002);
    tick(2);
    send_done();
    count_starts(20, n);
    chk("ow_once", 32'(n), 32'd0);

    // watchdog abort, sticky flag, next pending still launches
    strobe(1'b0, 16'h0, 1'b1, 16'hBEEF);
    wait_start("to", 1'b1, 16'hBEEF);
    tick();
    strobe(1'b1, 16'hAAAA, 1'b0, 16'h0);
    tick(48);
    chk("to_early",   32'(bus.o_timeout), 32'd0);
    chk("to_selhold", 32'(bus.o_tx_sel),  32'd1);
    tick();
    chk("to_flag", 32'(bus.o_timeout), 32'd1);
    tick();
    send_done();
    tick(2);
    chk("to_gap", 32'(bus.o_tx_start), 32'd0);
    tick();
    chk("to_next",   32'(bus.o_tx_start), 32'd1);
    chk("to_nxdata", 32'(bus.o_tx_data),  32'hAAAA);
    chk("to_sticky", 32'(bus.o_timeout),  32'd1);

    // async reset in WAIT drops everything, pending B5 is lost
    tick(2);
    strobe(1'b0, 16'h0, 1'b1, 16'h7777);
    i_reset = 1'b1;
    #1;
    chk_zero("mid_rst");
    tick(2);
    i_reset = 1'b0;
    count_starts(130, n);
    chk("rst_lost", 32'(n), 32'd0);

    // round-robin: B1 wins the first tie after reset, then alternates
    strobe(1'b1, 16'h1111, 1'b1, 16'h5555);
    wait_start("rr1", 1'b0, 16'h1111);
    tick();
    send_done();
    wait_start("rr2", 1'b1, 16'h5555);
    tick();
    strobe(1'b1, 16'h2222, 1'b1, 16'h6666);
    send_done();
    wait_start("rr3", 1'b0, 16'h2222);
    tick();
    send_done();
    wait_start("rr4", 1'b1, 16'h6666);
    tick();
    send_done();

    // strobe in the launch cycle: old word goes now, new word next
    tick(8);
    strobe(1'b1, 16'h3333, 1'b0, 16'h0);
    strobe(1'b1, 16'h4444, 1'b0, 16'h0);
    chk("same_start", 32'(bus.o_tx_start), 32'd1);
    chk("same_old",   32'(bus.o_tx_data),  32'h3333);
    tick();
    send_done();
    wait_start("same_new", 1'b0, 16'h4444);
    tick();
    send_done();

    // repeat of the last sent word
    tick(8);
    strobe(1'b0, 16'h0, 1'b1, 16'hCC10);
    wait_start("dd1", 1'b1, 16'hCC10);
    tick();
    send_done();
    tick(8);
    strobe(1'b0, 16'h0, 1'b1, 16'hCC10);
`ifdef SWIRE_SCHED_DEDUP_EN
    count_starts(30, n);
    chk("dd_rpt", 32'(n), 32'd0);
`else
    wait_start("dd_rpt", 1'b1, 16'hCC10);
    tick();
    send_done();
    tick(8);
`endif
    strobe(1'b0, 16'h0, 1'b1, 16'hCC11);
    wait_start("dd_new", 1'b1, 16'hCC11);
    tick();
    send_done();
    tick(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
